// File: rtl/watchdog_array.sv
// watchdog_array: NCH independent watchdog timers, each one-shot or auto-reload,
// with a one-cycle timeout pulse and a sticky status flag per channel.
module watchdog_array #(
  parameter int NCH = 4,
  parameter int CW  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    halt,
  input  logic [NCH-1:0]    kick,
  input  logic [NCH*CW-1:0] limit,
  input  logic [NCH-1:0]    reload,
  input  logic [NCH-1:0]    sts_clr,
  output logic [NCH*CW-1:0] cnt,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    timeout,
  output logic [NCH-1:0]    sts,
  output logic              any_sts
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e                  st_q [NCH];
  state_e                  st_d [NCH];
  logic [NCH-1:0][CW-1:0]  cnt_q, cnt_d, lim_q, lim_d;
  logic [NCH-1:0]          mode_q, mode_d, timeout_q, timeout_d, sts_q, sts_d;
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    mode_d    = mode_q;
    timeout_d = '0;
    // Priority per channel: halt > start > kick > terminal > increment
    for (int i = 0; i < NCH; i++) begin
      if (halt[i]) begin
        st_d[i]  = IDLE;
        cnt_d[i] = '0;
      end else if (start[i]) begin
        st_d[i]   = RUN;
        cnt_d[i]  = '0;
        lim_d[i]  = limit[i*CW +: CW];
        mode_d[i] = reload[i];
      end else if (st_q[i] == IDLE || kick[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == lim_q[i]) begin
        cnt_d[i]     = '0;
        timeout_d[i] = 1'b1;
        st_d[i]      = mode_q[i] ? RUN : IDLE;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    sts_d = (sts_q & ~sts_clr) | timeout_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '{default: IDLE};
      cnt_q     <= '0;
      lim_q     <= '0;
      mode_q    <= '0;
      timeout_q <= '0;
      sts_q     <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      sts_q     <= sts_d;
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_busy
    assign busy[g] = st_q[g] == RUN;
  end
  assign cnt     = cnt_q;
  assign timeout = timeout_q;
  assign sts     = sts_q;
  assign any_sts = |sts_q;
endmodule

// File: tb/tb_watchdog_array.sv
// tb_watchdog_array: directed stimulus pushes expected timeout pulses and state
// snapshots into queues; a negedge monitor pops and compares them by cycle.
module tb_watchdog_array;
  localparam int NCH = 4;
  localparam int CW  = 9;
  localparam int S_CNT = 0, S_BUSY = 1, S_STS = 2, S_ANY = 3, S_CNTALL = 4,
                 S_BUSYALL = 5, S_STSALL = 6, S_TOALL = 7;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    start = '0, halt = '0, kick = '0, reload = '0, sts_clr = '0;
  logic [NCH*CW-1:0] limit = '0;
  logic [NCH*CW-1:0] cnt;
  logic [NCH-1:0]    busy, timeout, sts;
  logic              any_sts;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  typedef struct { int cyc; logic [NCH-1:0] v; } to_t;
  typedef struct { int cyc; int sel; int ch; logic [63:0] exp; string name; } snap_t;
  to_t   to_q[$];
  snap_t snaps[$];
  watchdog_array #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .kick(kick), .limit(limit),
    .reload(reload), .sts_clr(sts_clr), .cnt(cnt), .busy(busy), .timeout(timeout),
    .sts(sts), .any_sts(any_sts)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask
  function automatic logic [63:0] sample(int sel, int ch);
    case (sel)
      S_CNT:     return 64'(cnt[ch*CW +: CW]);
      S_BUSY:    return 64'(busy[ch]);
      S_STS:     return 64'(sts[ch]);
      S_ANY:     return 64'(any_sts);
      S_CNTALL:  return 64'(cnt);
      S_BUSYALL: return 64'(busy);
      S_STSALL:  return 64'(sts);
      default:   return 64'(timeout);
    endcase
  endfunction
  task automatic at(int c, int sel, int ch, logic [63:0] v, string nm);
    snaps.push_back('{c, sel, ch, v, nm});
  endtask
  task automatic exp_to(int c, logic [NCH-1:0] v);
    to_q.push_back('{c, v});
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_lim(int ch, int v);
    limit[ch*CW +: CW] = CW'(v);
  endtask
  logic [NCH-1:0] ev;
  always @(negedge clk) begin
    ev = '0;
    for (int i = to_q.size() - 1; i >= 0; i--)
      if (to_q[i].cyc == cyc) begin
        ev |= to_q[i].v;
        to_q.delete(i);
      end
    if (timeout != '0 || ev != '0) chk("timeout", 64'(timeout), 64'(ev));
    for (int i = snaps.size() - 1; i >= 0; i--)
      if (snaps[i].cyc == cyc) begin
        chk(snaps[i].name, sample(snaps[i].sel, snaps[i].ch), snaps[i].exp);
        snaps.delete(i);
      end
  end
  initial begin
    int e0, e1;
    step(3);
    at(cyc + 1, S_CNTALL, 0, 0, "rst_cnt");
    at(cyc + 1, S_BUSYALL, 0, 0, "rst_busy");
    at(cyc + 1, S_STSALL, 0, 0, "rst_sts");
    at(cyc + 1, S_ANY, 0, 0, "rst_any");
    step(1);
    rst = 1'b0;
    step(1);
    // one-shot, ch0 limit 5
    e0 = cyc + 1;
    set_lim(0, 5); start[0] = 1'b1;
    at(e0, S_BUSY, 0, 1, "os_busy");
    at(e0, S_CNT, 0, 0, "os_cnt0");
    at(e0 + 3, S_CNT, 0, 3, "os_cnt3");
    at(e0 + 5, S_CNT, 0, 5, "os_cnt5");
    at(e0 + 5, S_STS, 0, 0, "os_sts_pre");
    exp_to(e0 + 6, 4'b0001);
    at(e0 + 6, S_BUSY, 0, 0, "os_busy_end");
    at(e0 + 6, S_CNT, 0, 0, "os_cnt_end");
    at(e0 + 6, S_STS, 0, 1, "os_sts");
    at(e0 + 6, S_ANY, 0, 1, "os_any");
    step(1); start[0] = 1'b0;
    step(8);
    sts_clr[0] = 1'b1;
    at(cyc + 1, S_STS, 0, 0, "os_sts_clr");
    step(1); sts_clr[0] = 1'b0;
    // auto-reload, ch1 limit 3, halted at E10
    e0 = cyc + 1;
    set_lim(1, 3); reload[1] = 1'b1; start[1] = 1'b1;
    exp_to(e0 + 4, 4'b0010);
    exp_to(e0 + 8, 4'b0010);
    at(e0 + 4, S_BUSY, 1, 1, "ar_busy4");
    at(e0 + 8, S_BUSY, 1, 1, "ar_busy8");
    at(e0 + 9, S_CNT, 1, 1, "ar_cnt9");
    at(e0 + 10, S_BUSY, 1, 0, "ar_halt_busy");
    at(e0 + 10, S_CNT, 1, 0, "ar_halt_cnt");
    step(1); start[1] = 1'b0; reload[1] = 1'b0;
    step(9); halt[1] = 1'b1;
    step(1); halt[1] = 1'b0;
    step(5);
    // kick collides with terminal, ch2 limit 4
    e0 = cyc + 1;
    set_lim(2, 4); start[2] = 1'b1;
    at(e0 + 4, S_CNT, 2, 4, "kk_cnt4");
    at(e0 + 5, S_CNT, 2, 0, "kk_cnt_kicked");
    at(e0 + 5, S_BUSY, 2, 1, "kk_busy");
    at(e0 + 9, S_CNT, 2, 4, "kk_cnt_again");
    exp_to(e0 + 10, 4'b0100);
    step(1); start[2] = 1'b0;
    step(4); kick[2] = 1'b1;
    step(1); kick[2] = 1'b0;
    step(7);
    kick[2] = 1'b1;
    at(cyc + 1, S_BUSY, 2, 0, "kk_idle_busy");
    at(cyc + 1, S_CNT, 2, 0, "kk_idle_cnt");
    step(1); kick[2] = 1'b0;
    // retrigger with new limit, ch3
    e0 = cyc + 1;
    set_lim(3, 10); start[3] = 1'b1;
    at(e0 + 6, S_CNT, 3, 6, "rt_cnt6");
    step(1); start[3] = 1'b0;
    step(6); start[3] = 1'b1; set_lim(3, 2);
    e1 = cyc + 1;
    at(e1, S_CNT, 3, 0, "rt_cnt0");
    at(e1 + 2, S_CNT, 3, 2, "rt_cnt2");
    at(e1 + 3, S_BUSY, 3, 0, "rt_busy_end");
    exp_to(e1 + 3, 4'b1000);
    step(1); start[3] = 1'b0; set_lim(3, 7);
    step(6);
    sts_clr = '1;
    at(cyc + 1, S_ANY, 0, 0, "clr_all_any");
    step(1); sts_clr = '0;
    // limit 0 auto-reload on ch0, sts_clr held through the pulses
    e0 = cyc + 1;
    set_lim(0, 0); reload[0] = 1'b1; start[0] = 1'b1;
    at(e0, S_BUSY, 0, 1, "z_busy");
    at(e0, S_CNT, 0, 0, "z_cnt");
    for (int k = 1; k <= 4; k++) exp_to(e0 + k, 4'b0001);
    at(e0 + 3, S_STS, 0, 1, "z_sts_set_wins");
    at(e0 + 4, S_STS, 0, 1, "z_sts_set_wins2");
    at(e0 + 4, S_BUSY, 0, 1, "z_busy4");
    at(e0 + 5, S_STS, 0, 0, "z_sts_cleared");
    at(e0 + 5, S_ANY, 0, 0, "z_any_cleared");
    at(e0 + 5, S_BUSY, 0, 0, "z_halt_busy");
    step(1); start[0] = 1'b0; reload[0] = 1'b0;
    step(1); sts_clr[0] = 1'b1;
    step(3); halt[0] = 1'b1;
    step(1); halt[0] = 1'b0; sts_clr[0] = 1'b0;
    step(2);
    // full-range limit 511 on ch1
    e0 = cyc + 1;
    set_lim(1, 511); start[1] = 1'b1;
    at(e0 + 511, S_CNT, 1, 511, "max_cnt511");
    at(e0 + 511, S_BUSY, 1, 1, "max_busy");
    at(e0 + 512, S_CNT, 1, 0, "max_cnt_nowrap");
    at(e0 + 512, S_BUSY, 1, 0, "max_busy_end");
    at(e0 + 512, S_STS, 1, 1, "max_sts");
    exp_to(e0 + 512, 4'b0010);
    step(1); start[1] = 1'b0;
    step(514);
    // reset while every channel runs
    e0 = cyc + 1;
    for (int c = 0; c < NCH; c++) set_lim(c, 20);
    start = '1;
    at(e0 + 4, S_BUSYALL, 0, 64'hF, "mr_busy_all");
    at(e0 + 4, S_CNTALL, 0, 64'({9'd4, 9'd4, 9'd4, 9'd4}), "mr_cnt_all");
    at(e0 + 5, S_CNTALL, 0, 0, "mr_cnt_rst");
    at(e0 + 5, S_BUSYALL, 0, 0, "mr_busy_rst");
    at(e0 + 5, S_STSALL, 0, 0, "mr_sts_rst");
    at(e0 + 5, S_TOALL, 0, 0, "mr_to_rst");
    at(e0 + 5, S_ANY, 0, 0, "mr_any_rst");
    step(1); start = '0;
    step(4); rst = 1'b1;
    step(1); rst = 1'b0;
    step(3);
    e0 = cyc + 1;
    set_lim(0, 2); start[0] = 1'b1;
    at(e0, S_BUSY, 0, 1, "pr_busy");
    exp_to(e0 + 3, 4'b0001);
    step(1); start[0] = 1'b0;
    step(25);
    chk("snap_queue_empty", 64'(snaps.size()), 0);
    chk("timeout_queue_empty", 64'(to_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/watchdog_array.md
WATCHDOG_ARRAY -- requirements
Module: watchdog_array

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent watchdog channels (1..32).
REQ-002 SHALL have parameter CW, default 9: counter and limit width per channel (2..32).
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  NCH: per-channel start/retrigger pulse.
REQ-006 SHALL have port halt  input  NCH: per-channel abort.
REQ-007 SHALL have port kick  input  NCH: per-channel service; restarts the count while running.
REQ-008 SHALL have port limit  input  NCH*CW: per-channel terminal count; channel i occupies bits [i*CW +: CW].
REQ-009 SHALL have port reload  input  NCH: per-channel mode; 0 = one-shot, 1 = auto-reload.
REQ-010 SHALL have port sts_clr  input  NCH: per-channel sticky-status clear.
REQ-011 SHALL have port cnt  output  NCH*CW: per-channel current count, registered.
REQ-012 SHALL have port busy  output  NCH: channel running, registered.
REQ-013 SHALL have port timeout  output  NCH: one-cycle timeout pulse, registered.
REQ-014 SHALL have port sts  output  NCH: sticky timeout flag, registered.
REQ-015 SHALL have port any_sts  output  1: OR of all sts bits.

Function
REQ-016 Each channel SHALL be an independent two-state FSM: IDLE (busy=0) and RUN (busy=1); there SHALL be no cross-channel interaction except any_sts.
REQ-017 Per channel, per edge, event priority SHALL be: halt > start > kick > terminal > increment.
REQ-018 halt SHALL force cnt=0, busy=0, timeout=0, in any state, even when terminal or start occurs in the same cycle.
REQ-019 start (no halt) SHALL force cnt=0, busy=1, and latch limit and reload into internal lim_q/mode_q, from IDLE or RUN (retrigger).
REQ-020 limit and reload SHALL be sampled only on start; changes during RUN SHALL have no effect.
REQ-021 kick in RUN (no halt/start) SHALL force cnt=0 and suppress timeout, even when cnt==lim_q; kick in IDLE SHALL be ignored.
REQ-022 Terminal = RUN and cnt==lim_q with no halt/start/kick; on terminal: cnt=0, timeout=1 next cycle, busy=mode_q.
REQ-023 Otherwise in RUN, cnt SHALL increment by 1 per cycle; in IDLE, cnt SHALL hold 0.
REQ-024 Latency: start sampled at edge E0 -> busy=1 after E0; cnt=n after E0+n; timeout=1 after E0+lim_q+1 for exactly one cycle.
REQ-025 Auto-reload period SHALL be lim_q+1 cycles between timeout pulses, with busy staying 1.
REQ-026 cnt SHALL never exceed lim_q and SHALL never wrap; lim_q = 2^CW-1 SHALL be legal; lim_q = 0 SHALL give timeout one cycle after start, every cycle in auto-reload.
REQ-027 timeout SHALL be 0 in every cycle not following a terminal event.
REQ-028 sts[i] SHALL set on the edge that asserts timeout[i] and clear on sts_clr[i]; set SHALL win over simultaneous clear.
REQ-029 any_sts SHALL be the combinational OR of registered sts.

Reset
REQ-030 While rst=1 at an edge: cnt=0, busy=0, timeout=0, sts=0, lim_q=0, mode_q=0 for all channels; all other inputs ignored.
REQ-031 Reset mid-RUN SHALL abort without timeout; the first start after rst deasserts SHALL behave per REQ-019.

Verification
REQ-032 One-shot: ch0 limit=5, reload=0, start at E0 -> cnt 0..5, timeout[0]=1 after E6 only, busy=0 after E6, sts[0]=1, any_sts=1.
REQ-033 Auto-reload: ch1 limit=3, reload=1 -> timeout[1] after E4, E8, E12; busy stays 1; halt at E10 -> busy=0, cnt=0, no pulse at E12.
REQ-034 Kick/terminal collision: ch2 limit=4, kick at the edge where cnt==4 -> cnt=0, no timeout; next timeout 5 cycles later.
REQ-035 Retrigger plus limit change: ch3 start limit=10; at cnt=6, start with limit=2 -> cnt=0, timeout 3 cycles later; limit change without start -> no effect.
REQ-036 Boundaries: limit=0 auto-reload -> timeout every cycle; CW=9, limit=511 -> timeout after 512 cycles, no wrap; sts_clr coincident with timeout -> sts stays 1.
REQ-037 Reset mid-run: rst=1 while all channels busy -> all outputs 0 next cycle, no timeout pulse.
